// File: rtl/sram_access_controller_pkg.sv
// Shared types and constants for the SRAM access controller: FSM state encoding,
// default address map and halfword select values.
package sram_access_controller_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLow,
    StHigh,
    StDone
  } sram_state_t;

  localparam logic [31:0] DefaultBaseAddr = 32'd1024;

  localparam logic HalfLow  = 1'b0;
  localparam logic HalfHigh = 1'b1;

  // Word index relative to the SRAM base; callers keep only the bits they can address.
  function automatic logic [31:0] word_offset(input logic [31:0] address,
                                              input logic [31:0] base);
    return (address - base) >> 2;
  endfunction

endpackage

// File: rtl/sram_access_controller_wait_counter.sv
// Phase wait counter: counts 0..WAIT_CYCLES-1 and flags the terminal count.
// A synchronous clear reloads zero at the start of every halfword phase.
module sram_wait_counter #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned CNT_W       = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next,
  output logic             tc
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;
  assign tc         = (count_q == CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_access_controller.sv
// Memory-stage controller: moves one 32-bit load/store over a 16-bit async SRAM
// as two timed halfword phases (low half first), holding the pipeline meanwhile.
module sram_access_controller
  import sram_access_controller_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DefaultBaseAddr,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_ADDR_W = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  localparam int unsigned CntW  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned WordW = SRAM_ADDR_W - 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);

  sram_state_t state_q, state_d;

  logic             req;
  logic [31:0]      offset;
  logic [WordW-1:0] word_in;
  logic             unused_offset;

  logic             is_write_q;
  logic [WordW-1:0] word_q;
  logic [31:0]      wdata_q;
  logic [31:0]      read_data_q;

  logic             op_write;
  logic [WordW-1:0] op_word;
  logic [31:0]      op_wdata;

  logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]            dq_out_q, dq_out_d;
  logic                   oe_q, oe_d;
  logic                   we_n_q, we_n_d;
  logic                   half;

  logic            cnt_clr, cnt_en, cnt_tc;
  logic [CntW-1:0] cnt, cnt_next;
  logic            capture_lo, capture_hi;

  assign req           = rd_en | wr_en;
  assign offset        = word_offset(address, BASE_ADDR);
  assign word_in       = offset[WordW-1:0];
  assign unused_offset = ^offset[31:WordW];

  // In IDLE the access being launched is described by the live pipeline inputs;
  // afterwards the latched copy keeps the access coherent even if the request drops.
  assign op_write = (state_q == StIdle) ? wr_en      : is_write_q;
  assign op_word  = (state_q == StIdle) ? word_in    : word_q;
  assign op_wdata = (state_q == StIdle) ? write_data : wdata_q;

  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .CNT_W       (CntW)
  ) u_wait_counter (
    .clk        (clk),
    .rst        (rst),
    .clr        (cnt_clr),
    .en         (cnt_en),
    .count      (cnt),
    .count_next (cnt_next),
    .tc         (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    ready   = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready = !req;
        if (req) begin
          state_d = StLow;
          cnt_clr = 1'b1;
        end
      end
      StLow: begin
        if (cnt_tc) begin
          state_d = StHigh;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      StHigh: begin
        if (cnt_tc) begin
          state_d = StDone;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      StDone: begin
        ready   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Pin values are computed from the next state and registered, so the SRAM
  // strobe and bus enable come straight from flops and cannot glitch.
  always_comb begin
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    oe_d        = 1'b0;
    we_n_d      = 1'b1;
    half        = HalfLow;
    if (state_d == StLow || state_d == StHigh) begin
      half        = (state_d == StHigh) ? HalfHigh : HalfLow;
      sram_addr_d = {op_word, half};
      if (op_write) begin
        dq_out_d = (half == HalfHigh) ? op_wdata[31:16] : op_wdata[15:0];
        oe_d     = 1'b1;
        // Strobe released on the last wait cycle so data is held past we_n rising.
        we_n_d   = (cnt_next == CntLast);
      end
    end
  end

  assign capture_lo = (state_q == StLow)  && cnt_tc && !is_write_q;
  assign capture_hi = (state_q == StHigh) && cnt_tc && !is_write_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      is_write_q  <= 1'b0;
      word_q      <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      oe_q        <= 1'b0;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      oe_q        <= oe_d;
      we_n_q      <= we_n_d;
      if (state_q == StIdle) begin
        is_write_q <= wr_en;
        word_q     <= word_in;
        wdata_q    <= write_data;
      end
      if (capture_lo) begin
        read_data_q[15:0] <= sram_dq_in;
      end
      if (capture_hi) begin
        read_data_q[31:16] <= sram_dq_in;
      end
    end
  end

  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = oe_q;
  assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_access_controller.sv
// Bench for sram_access_controller: table-driven directed vectors, reset-abort and
// WAIT_CYCLES=4 sequences, then random loads/stores against a word-level memory model.
module tb_sram_access_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  logic        rd_en4, wr_en4;
  logic [31:0] address4, write_data4, read_data4;
  logic        ready4;
  logic [17:0] sram_addr4;
  logic [15:0] sram_dq_out4, sram_dq_in4;
  logic        sram_dq_oe4, sram_we_n4;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_access_controller u_dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n)
  );

  sram_access_controller #(
    .WAIT_CYCLES (4)
  ) u_dut4 (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en4),
    .wr_en       (wr_en4),
    .address     (address4),
    .write_data  (write_data4),
    .read_data   (read_data4),
    .ready       (ready4),
    .sram_addr   (sram_addr4),
    .sram_dq_out (sram_dq_out4),
    .sram_dq_in  (sram_dq_in4),
    .sram_dq_oe  (sram_dq_oe4),
    .sram_we_n   (sram_we_n4)
  );

  // Power-up SRAM contents; halfwords 4/5 hold the directed load pattern.
  function automatic logic [15:0] sram_init(input logic [17:0] h);
    logic [31:0] t;
    if (h == 18'd4) return 16'h5678;
    if (h == 18'd5) return 16'h1234;
    t = (32'(h) * 32'h9E37) ^ 32'h5A5A;
    return t[15:0];
  endfunction

  logic [15:0] mem [0:262143];
  bit          written [0:262143];

  always @(posedge clk) begin
    if (!sram_we_n) begin
      mem[sram_addr]     <= sram_dq_out;
      written[sram_addr] <= 1'b1;
    end
  end
  assign sram_dq_in  = written[sram_addr] ? mem[sram_addr] : sram_init(sram_addr);
  assign sram_dq_in4 = sram_init(sram_addr4);

  // Word-level reference: 32-bit words keyed by SRAM word index.
  logic [31:0] ref_mem [logic [16:0]];
  logic [31:0] last_load = 32'h0;

  function automatic logic [16:0] word_of(input logic [31:0] a);
    logic [31:0] t;
    t = (a - 32'd1024) >> 2;
    return t[16:0];
  endfunction

  function automatic logic [31:0] model_read(input logic [16:0] w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return {sram_init({w, 1'b1}), sram_init({w, 1'b0})};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  logic [17:0] rec_addr [64];
  logic [15:0] rec_dq   [64];
  logic        rec_we   [64];
  logic        rec_oe   [64];
  logic        rec_rdy  [64];
  logic [31:0] done_rdata;
  int          done_cyc;

  // Presents one request at IDLE and follows it to DONE; returns in the next IDLE cycle.
  task automatic run_access(input logic w, input logic r, input logic [31:0] a,
                            input logic [31:0] d, output int lat);
    wr_en = w; rd_en = r; address = a; write_data = d;
    lat = -1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      rec_addr[k] = sram_addr; rec_dq[k] = sram_dq_out;
      rec_we[k] = sram_we_n; rec_oe[k] = sram_dq_oe; rec_rdy[k] = ready;
      if (ready && k > 0) begin
        lat = k; done_rdata = read_data; done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic check_access(input string tag, input logic w, input logic [31:0] d,
                              input int lat, input logic [17:0] lo, input logic [31:0] exp_rd);
    chk({tag, "_latency"}, 32'(lat), 32'd5);
    chk({tag, "_ready_c0"}, 32'(rec_rdy[0]), 32'd0);
    if (lat == 5) begin
      chk({tag, "_addr_c1"}, 32'(rec_addr[1]), 32'(lo));
      chk({tag, "_addr_c2"}, 32'(rec_addr[2]), 32'(lo));
      chk({tag, "_addr_c3"}, 32'(rec_addr[3]), 32'(lo | 18'd1));
      chk({tag, "_addr_c4"}, 32'(rec_addr[4]), 32'(lo | 18'd1));
      chk({tag, "_we_c1"}, 32'(rec_we[1]), 32'(!w));
      chk({tag, "_we_c2"}, 32'(rec_we[2]), 32'd1);
      chk({tag, "_we_c3"}, 32'(rec_we[3]), 32'(!w));
      chk({tag, "_we_c4"}, 32'(rec_we[4]), 32'd1);
      chk({tag, "_oe_c1"}, 32'(rec_oe[1]), 32'(w));
      chk({tag, "_oe_done"}, 32'(rec_oe[5]) | 32'(!rec_we[5]), 32'd0);
      if (w) begin
        chk({tag, "_dq_lo"}, 32'(rec_dq[1]), 32'(d[15:0]));
        chk({tag, "_dq_hi"}, 32'(rec_dq[3]), 32'(d[31:16]));
      end
    end
    chk({tag, "_read_data"}, done_rdata, exp_rd);
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic [17:0] exp_lo;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int          lat, we_low, prev_done;
    logic        w, r;
    logic [31:0] a, d, exp_rd;
    logic [16:0] wd;

    vecs[0] = '{1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'h00000000, 18'h00000};
    vecs[1] = '{1'b0, 1'b1, 32'd1032, 32'h00000000, 32'h12345678, 18'h00004};
    vecs[2] = '{1'b1, 1'b1, 32'd1020, 32'h0BADC0DE, 32'h12345678, 18'h3FFFE};
    vecs[3] = '{1'b0, 1'b1, 32'd1020, 32'h00000000, 32'h0BADC0DE, 18'h3FFFE};
    vecs[4] = '{1'b0, 1'b1, 32'd1026, 32'h00000000, 32'hDEADBEEF, 18'h00000};
    vecs[5] = '{1'b1, 1'b0, 32'd1056, 32'hCAFEF00D, 32'hDEADBEEF, 18'h00010};
    vecs[6] = '{1'b0, 1'b1, 32'd1056, 32'h00000000, 32'hCAFEF00D, 18'h00010};

    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    rd_en4 = 1'b0; wr_en4 = 1'b0; address4 = '0; write_data4 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_we_n", 32'(sram_we_n), 32'd1);
    chk("reset_oe", 32'(sram_dq_oe), 32'd0);
    chk("reset_read_data", read_data, 32'd0);
    chk("reset_addr", 32'(sram_addr), 32'd0);
    chk("reset_dq_out", 32'(sram_dq_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed table, issued back to back.
    prev_done = 0;
    for (int i = 0; i < 7; i++) begin
      run_access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, lat);
      check_access($sformatf("vec%0d", i), vecs[i].wr, vecs[i].data, lat,
                   vecs[i].exp_lo, vecs[i].exp_rd);
      if (i > 0) chk($sformatf("vec%0d_done_gap", i), 32'(done_cyc - prev_done), 32'd6);
      prev_done = done_cyc;
      if (vecs[i].wr) ref_mem[word_of(vecs[i].addr)] = vecs[i].data;
      else last_load = vecs[i].exp_rd;
    end

    // Abort a store during its HIGH phase.
    wr_en = 1'b1; address = 32'd1424; write_data = 32'h11112222;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort_pre_addr", 32'(sram_addr), 32'd201);
    chk("abort_pre_we_n", 32'(sram_we_n), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_we_n", 32'(sram_we_n), 32'd1);
    chk("abort_oe", 32'(sram_dq_oe), 32'd0);
    chk("abort_read_data", read_data, 32'd0);
    chk("abort_ready_req", 32'(ready), 32'd0);
    wr_en = 1'b0;
    #1;
    chk("abort_ready_idle", 32'(ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    last_load = 32'h0;

    // Random traffic against the word-level model.
    for (int n = 0; n < 40; n++) begin
      w = 1'($urandom_range(0, 1));
      r = w ? ($urandom_range(0, 3) == 0) : 1'b1;
      a = (($urandom_range(0, 7) == 0) ? 32'd1020 : 32'd1024 + 32'($urandom_range(0, 15)) * 4)
          + 32'($urandom_range(0, 3));
      d = $urandom;
      wd = word_of(a);
      exp_rd = w ? last_load : model_read(wd);
      run_access(w, r, a, d, lat);
      check_access($sformatf("rnd%0d", n), w, d, lat, {wd, 1'b0}, exp_rd);
      if (w) ref_mem[wd] = d;
      else last_load = exp_rd;
    end

    // WAIT_CYCLES = 4 instance: store then load.
    wr_en4 = 1'b1; address4 = 32'd1036; write_data4 = 32'hA5A55A5A;
    lat = -1; we_low = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      rec_addr[k] = sram_addr4; rec_we[k] = sram_we_n4;
      if (!sram_we_n4) we_low++;
      if (ready4 && k > 0) begin lat = k; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    wr_en4 = 1'b0;
    chk("w4_store_latency", 32'(lat), 32'd9);
    chk("w4_we_low_cycles", 32'(we_low), 32'd6);
    chk("w4_addr_c1", 32'(rec_addr[1]), 32'd6);
    chk("w4_addr_c5", 32'(rec_addr[5]), 32'd7);
    chk("w4_we_c3", 32'(rec_we[3]), 32'd0);
    chk("w4_we_c4", 32'(rec_we[4]), 32'd1);

    rd_en4 = 1'b1; address4 = 32'd1044;
    lat = -1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (ready4 && k > 0) begin lat = k; done_rdata = read_data4; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    rd_en4 = 1'b0;
    chk("w4_load_latency", 32'(lat), 32'd9);
    chk("w4_load_data", done_rdata, {sram_init(18'd11), sram_init(18'd10)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
